conv2d_ctrl: RTL and testbench

- Sequencer for the 3x3 convolution datapath: three row filters (filter_0/1/2) feeding conv2D_out.
- On a start pulse, sweeps a SIDE x SIDE 4-bit image held in a synchronous-read pixel memory (1-cycle read latency).
- Issues three row addresses per cycle (rows r, r+1, r+2; column c) and drives the datapath EN and OE.
- Tags every valid output with its (row, col) coordinate; supports a hold/stall input and a done handshake.

---
 rtl/conv2d_ctrl_if.sv | 32 +++
 rtl/conv2d_ctrl.sv | 162 ++++++++++++++++
 tb/tb_conv2d_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_ctrl_if.sv
// Handshake and address bus between the convolution sequencer and the
// pixel memory / filter datapath it steers.
interface conv2d_ctrl_if #(
  parameter int ADDR_W = 6
) ();

  logic              start;
  logic              hold;
  logic              memRe;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic              en;
  logic              oe;
  logic [ADDR_W-1:0] outRow;
  logic [ADDR_W-1:0] outCol;
  logic              busy;
  logic              done;

  // The sequencer side: takes start/hold, drives everything else
  modport master (
    input  start, hold,
    output memRe, addr0, addr1, addr2, en, oe, outRow, outCol, busy, done
  );

  // The requester / datapath side
  modport slave (
    output start, hold,
    input  memRe, addr0, addr1, addr2, en, oe, outRow, outCol, busy, done
  );

endinterface

// File: rtl/conv2d_ctrl.sv
// Sequencer for the 3x3 convolution datapath. Sweeps a SIDE x SIDE image,
// issuing three vertically adjacent pixel addresses per cycle, and tags each
// valid filter output with its (row, col) window coordinate.
module conv2d_ctrl #(
  parameter int SIDE     = 6,
  parameter int ADDR_W   = 6,
  parameter int PIPE_LAT = 3
) (
  input logic           clk_i,
  input logic           rst_ni,
  conv2d_ctrl_if.master bus_io
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_W-1:0] SIDE_A     = ADDR_W'(SIDE);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(SIDE - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(SIDE - 3);
  localparam logic [DW-1:0]     LAST_DRAIN = DW'(PIPE_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [DW-1:0]     drain_q, drain_d;

  logic [ADDR_W-1:0] lastAddr0_q, lastAddr1_q, lastAddr2_q;

  logic              pipeValid_q [PIPE_LAT];
  logic [ADDR_W-1:0] pipeRow_q   [PIPE_LAT];
  logic [ADDR_W-1:0] pipeCol_q   [PIPE_LAT];

  logic              running;
  logic              advance;
  logic              issue;
  logic              oeInt;
  logic [ADDR_W-1:0] rowAddr0, rowAddr1, rowAddr2;

  // The sweep and the datapath only move in RUN/DRAIN cycles that are not stalled
  assign running = (state_q == RUN) || (state_q == DRAIN);
  assign advance = running && !bus_io.hold;
  assign issue   = (state_q == RUN) && !bus_io.hold;

  // Rows r, r+1, r+2 of the current column are SIDE addresses apart
  assign rowAddr0 = row_q * SIDE_A + col_q;
  assign rowAddr1 = rowAddr0 + SIDE_A;
  assign rowAddr2 = rowAddr1 + SIDE_A;

  // Next-state logic for the sweep FSM and its row/column/drain counters
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      RUN: begin
        if (!bus_io.hold) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = DRAIN;
              drain_d = '0;
            end else begin
              row_d = row_q + ADDR_W'(1);
            end
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!bus_io.hold) begin
          if (drain_q == LAST_DRAIN) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
        drain_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  // Remember the last issued addresses so the bus stays put while stalled or draining
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastAddr0_q <= '0;
      lastAddr1_q <= '0;
      lastAddr2_q <= '0;
    end else if (issue) begin
      lastAddr0_q <= rowAddr0;
      lastAddr1_q <= rowAddr1;
      lastAddr2_q <= rowAddr2;
    end
  end

  // oe delay line: columns 0/1 enter as invalid so a window never mixes two rows
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeRow_q[i]   <= '0;
        pipeCol_q[i]   <= '0;
      end
    end else if (advance) begin
      pipeValid_q[0] <= issue && (col_q >= ADDR_W'(2));
      pipeRow_q[0]   <= row_q;
      pipeCol_q[0]   <= col_q - ADDR_W'(2);
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeRow_q[i]   <= pipeRow_q[i-1];
        pipeCol_q[i]   <= pipeCol_q[i-1];
      end
    end
  end

  assign oeInt = advance && pipeValid_q[PIPE_LAT-1];

  assign bus_io.memRe  = issue;
  assign bus_io.en     = advance;
  assign bus_io.addr0  = issue ? rowAddr0 : lastAddr0_q;
  assign bus_io.addr1  = issue ? rowAddr1 : lastAddr1_q;
  assign bus_io.addr2  = issue ? rowAddr2 : lastAddr2_q;
  assign bus_io.oe     = oeInt;
  assign bus_io.outRow = oeInt ? pipeRow_q[PIPE_LAT-1] : '0;
  assign bus_io.outCol = oeInt ? pipeCol_q[PIPE_LAT-1] : '0;
  assign bus_io.busy   = (state_q != IDLE);
  assign bus_io.done   = (state_q == DONE);

endmodule

// File: tb/tb_conv2d_ctrl.sv
// Self-checking bench for conv2d_ctrl. Expected outputs come from a frame
// model that counts non-stalled cycles since start and derives issues, oe
// tags and done from that count with plain arithmetic.
module tb_conv2d_ctrl;

  localparam int SIDE     = 6;
  localparam int ADDR_W   = 6;
  localparam int PIPE_LAT = 3;
  localparam int N        = (SIDE - 2) * SIDE;
  localparam int MAX_CYC  = 300;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  conv2d_ctrl_if #(.ADDR_W(ADDR_W)) busIf ();

  conv2d_ctrl #(
    .SIDE    (SIDE),
    .ADDR_W  (ADDR_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus_io(busIf)
  );

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              memRe;
    logic              en;
    logic              oe;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [ADDR_W-1:0] outRow;
    logic [ADDR_W-1:0] outCol;
  } outs_t;

  int vectors     = 0;
  int miscompares = 0;

  // Frame model state: active sweep, pending done cycle, non-stalled cycle count
  bit                mActive = 1'b0;
  bit                mDone   = 1'b0;
  int                mN      = 0;
  logic [ADDR_W-1:0] mLast0  = '0;
  logic [ADDR_W-1:0] mLast1  = '0;
  logic [ADDR_W-1:0] mLast2  = '0;

  // Reset drops the model back to idle with cleared addresses
  function automatic void modelReset();
    mActive = 1'b0;
    mDone   = 1'b0;
    mN      = 0;
    mLast0  = '0;
    mLast1  = '0;
    mLast2  = '0;
  endfunction

  // Expected outputs for one cycle given this cycle's start/hold inputs
  function automatic void modelStep(input logic s, input logic h, output outs_t e);
    int idx;
    int k;
    e = '0;
    if (mDone) begin
      e.busy = 1'b1;
      e.done = 1'b1;
      mDone  = 1'b0;
    end else if (mActive) begin
      e.busy = 1'b1;
      if (!h) begin
        mN++;
        e.en = 1'b1;
        if (mN <= N) begin
          idx     = mN - 1;
          e.memRe = 1'b1;
          mLast0  = ADDR_W'((idx / SIDE)     * SIDE + idx % SIDE);
          mLast1  = ADDR_W'((idx / SIDE + 1) * SIDE + idx % SIDE);
          mLast2  = ADDR_W'((idx / SIDE + 2) * SIDE + idx % SIDE);
        end
        k = mN - PIPE_LAT;
        if (k >= 1 && k <= N && ((k - 1) % SIDE) >= 2) begin
          e.oe     = 1'b1;
          e.outRow = ADDR_W'((k - 1) / SIDE);
          e.outCol = ADDR_W'((k - 1) % SIDE - 2);
        end
        if (mN == N + PIPE_LAT) begin
          mActive = 1'b0;
          mDone   = 1'b1;
        end
      end
    end else if (s) begin
      mActive = 1'b1;
      mN      = 0;
    end
    e.addr0 = mLast0;
    e.addr1 = mLast1;
    e.addr2 = mLast2;
  endfunction

  function automatic outs_t sampleOuts();
    outs_t o;
    o.busy   = busIf.busy;
    o.done   = busIf.done;
    o.memRe  = busIf.memRe;
    o.en     = busIf.en;
    o.oe     = busIf.oe;
    o.addr0  = busIf.addr0;
    o.addr1  = busIf.addr1;
    o.addr2  = busIf.addr2;
    o.outRow = busIf.outRow;
    o.outCol = busIf.outCol;
    return o;
  endfunction

  // Reset state: everything zero, and idle ignores a hold
  task automatic test_reset();
    outs_t act;
    busIf.start = 1'b0;
    busIf.hold  = 1'b0;
    rstN        = 1'b0;
    modelReset();
    #12;
    act = sampleOuts();
    vectors++;
    if (act !== outs_t'('0)) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h want %h", act, outs_t'('0));
    end
    @(negedge clk);
    rstN       = 1'b1;
    busIf.hold = 1'b1;
    @(negedge clk);
    #1;
    act = sampleOuts();
    vectors++;
    if (act.busy !== 1'b0 || act.en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_hold: busy %b en %b want 0 0", act.busy, act.en);
    end
    busIf.hold = 1'b0;
  endtask

  // Nominal unstalled frame: full cycle-by-cycle check plus frame totals
  task automatic test_nominal();
    outs_t act, exp;
    int doneCyc = -1;
    int firstOe = -1;
    int oeCount = 0;
    int lastIss = -1;
    for (int t = 0; t < MAX_CYC; t++) begin
      @(negedge clk);
      busIf.start = (t == 0);
      busIf.hold  = 1'b0;
      modelStep(busIf.start, busIf.hold, exp);
      #1;
      act = sampleOuts();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL nominal cyc %0d: got %h want %h", t, act, exp);
      end
      if (act.oe) begin
        oeCount++;
        if (firstOe < 0) firstOe = t;
      end
      if (act.memRe) lastIss = t;
      if (act.done && doneCyc < 0) doneCyc = t;
      if (doneCyc >= 0 && t == doneCyc + 1) break;
    end
    busIf.start = 1'b0;
    vectors++;
    if (doneCyc != N + PIPE_LAT + 1) begin
      miscompares++;
      $display("[TB] FAIL nominal_done_cycle: got %0d want %0d", doneCyc, N + PIPE_LAT + 1);
    end
    vectors++;
    if (oeCount != (SIDE - 2) * (SIDE - 2)) begin
      miscompares++;
      $display("[TB] FAIL nominal_oe_count: got %0d want %0d", oeCount, (SIDE - 2) * (SIDE - 2));
    end
    vectors++;
    if (firstOe != 2 + PIPE_LAT + 1) begin
      miscompares++;
      $display("[TB] FAIL nominal_first_oe: got %0d want %0d", firstOe, 2 + PIPE_LAT + 1);
    end
    vectors++;
    if (lastIss != N) begin
      miscompares++;
      $display("[TB] FAIL nominal_last_issue: got %0d want %0d", lastIss, N);
    end
  endtask

  // Three-cycle stall starting at cycle 10 pushes done out by three cycles
  task automatic test_stall();
    outs_t act, exp;
    int doneCyc = -1;
    int oeCount = 0;
    for (int t = 0; t < MAX_CYC; t++) begin
      @(negedge clk);
      busIf.start = (t == 0);
      busIf.hold  = (t >= 10 && t <= 12);
      modelStep(busIf.start, busIf.hold, exp);
      #1;
      act = sampleOuts();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL stall cyc %0d: got %h want %h", t, act, exp);
      end
      if (act.oe) oeCount++;
      if (act.done && doneCyc < 0) doneCyc = t;
      if (doneCyc >= 0 && t == doneCyc + 1) break;
    end
    busIf.start = 1'b0;
    busIf.hold  = 1'b0;
    vectors++;
    if (doneCyc != N + PIPE_LAT + 4) begin
      miscompares++;
      $display("[TB] FAIL stall_done_cycle: got %0d want %0d", doneCyc, N + PIPE_LAT + 4);
    end
    vectors++;
    if (oeCount != (SIDE - 2) * (SIDE - 2)) begin
      miscompares++;
      $display("[TB] FAIL stall_oe_count: got %0d want %0d", oeCount, (SIDE - 2) * (SIDE - 2));
    end
  endtask

  // Start re-pulsed while busy and in the done cycle must be ignored
  task automatic test_restart_ignored();
    outs_t act, exp;
    int doneCyc   = -1;
    int doneCount = 0;
    for (int t = 0; t < MAX_CYC; t++) begin
      @(negedge clk);
      busIf.start = (t == 0 || t == 5 || t == N + PIPE_LAT + 1);
      busIf.hold  = 1'b0;
      modelStep(busIf.start, busIf.hold, exp);
      #1;
      act = sampleOuts();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL restart cyc %0d: got %h want %h", t, act, exp);
      end
      if (act.done) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = t;
      end
      if (doneCyc >= 0 && t == doneCyc + 3) break;
    end
    busIf.start = 1'b0;
    vectors++;
    if (doneCount != 1 || doneCyc != N + PIPE_LAT + 1) begin
      miscompares++;
      $display("[TB] FAIL restart_done: got %0d pulses at %0d want 1 at %0d",
               doneCount, doneCyc, N + PIPE_LAT + 1);
    end
  endtask

  // Reset at cycle 15 aborts the frame; a fresh start then runs a full frame
  task automatic test_reset_midframe();
    outs_t act, exp;
    int doneCount = 0;
    int doneCyc   = -1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      busIf.start = (t == 0);
      busIf.hold  = 1'b0;
      modelStep(busIf.start, busIf.hold, exp);
      #1;
      act = sampleOuts();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL midreset pre cyc %0d: got %h want %h", t, act, exp);
      end
    end
    @(negedge clk);
    busIf.start = 1'b0;
    rstN        = 1'b0;
    modelReset();
    #1;
    act = sampleOuts();
    vectors++;
    if (act !== outs_t'('0)) begin
      miscompares++;
      $display("[TB] FAIL midreset_zero: got %h want %h", act, outs_t'('0));
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      if (busIf.done) doneCount++;
    end
    rstN = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      busIf.start = 1'b0;
      modelStep(1'b0, 1'b0, exp);
      #1;
      act = sampleOuts();
      if (act.done) doneCount++;
    end
    vectors++;
    if (doneCount != 0 || act !== exp) begin
      miscompares++;
      $display("[TB] FAIL midreset_abort: %0d done pulses, got %h want %h", doneCount, act, exp);
    end
    for (int t = 0; t < MAX_CYC; t++) begin
      @(negedge clk);
      busIf.start = (t == 0);
      busIf.hold  = 1'b0;
      modelStep(busIf.start, busIf.hold, exp);
      #1;
      act = sampleOuts();
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL midreset post cyc %0d: got %h want %h", t, act, exp);
      end
      if (act.done && doneCyc < 0) doneCyc = t;
      if (doneCyc >= 0 && t == doneCyc + 1) break;
    end
    busIf.start = 1'b0;
    vectors++;
    if (doneCyc != N + PIPE_LAT + 1) begin
      miscompares++;
      $display("[TB] FAIL midreset_rerun_done: got %0d want %0d", doneCyc, N + PIPE_LAT + 1);
    end
  endtask

  // Random stalls, random stray starts and random idle gaps across several frames
  task automatic test_random();
    outs_t act, exp;
    for (int f = 0; f < 6; f++) begin
      int gap       = int'($urandom_range(0, 3));
      int doneCyc   = -1;
      int doneCount = 0;
      for (int t = 0; t < MAX_CYC; t++) begin
        @(negedge clk);
        busIf.start = (t == gap) || (t > gap && doneCyc < 0 && $urandom_range(0, 7) == 0);
        busIf.hold  = ($urandom_range(0, 3) == 0);
        modelStep(busIf.start, busIf.hold, exp);
        #1;
        act = sampleOuts();
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("[TB] FAIL random f%0d cyc %0d: got %h want %h", f, t, act, exp);
        end
        if (act.done) begin
          doneCount++;
          if (doneCyc < 0) doneCyc = t;
        end
        if (doneCyc >= 0 && t == doneCyc + 1) break;
      end
      busIf.start = 1'b0;
      busIf.hold  = 1'b0;
      vectors++;
      if (doneCount != 1) begin
        miscompares++;
        $display("[TB] FAIL random f%0d done_count: got %0d want 1", f, doneCount);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_restart_ignored();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
